fp_multiply_top: RTL and testbench
==================================

# fp_multiply_top

Single-precision IEEE 754 floating-point multiplier with a fixed 3-stage pipeline. It is the multiply datapath used by the neural-network MAC path: it takes two binary32 operands every cycle and returns their product three rising edges later. It has no handshake, is always enabled, and accepts a new operand pair every cycle.

## Interface
- No parameters.
- clk_i  input  1  sole clock; all state updates on the rising edge.
- reset_i  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk_i.
- a_i  input  32  operand A, IEEE 754 binary32 (sign 31, exponent 30:23, fraction 22:0).
- b_i  input  32  operand B, same format.
- product_o  output  32  registered product a_i × b_i, binary32.

## Operation
- Sign = sign(a) XOR sign(b), including for zero results.
- Zero and denormal inputs (exponent 0) are treated as signed zero (flush-to-zero). If either operand is zero, the result is {sign, 31'b0}.
- Normal path:
  - Significands are 24 bits each, with the hidden 1 restored.
  - The unsigned product is 48 bits.
  - Biased exponent = ea + eb − 127, computed as a 10-bit signed value.
- Normalization:
  - If product bit 47 is set, shift right by 1 and increment the exponent.
  - The result mantissa is then product[46:24], or product[45:23] when bit 47 is clear.
- Rounding is round-to-nearest-even:
  - Guard bit is the first dropped bit; sticky is the OR of the remaining dropped bits.
  - Round up if guard AND (sticky OR lsb).
  - A mantissa carry-out renormalizes and increments the exponent again.
- Underflow: a final biased exponent ≤ 0 flushes to signed zero (no denormal outputs).
- Overflow: a final biased exponent ≥ 255 is handled per Configuration.
- Inputs with exponent 255 are handled per Configuration.

## Timing
- Stage 1 (edge N): register a_i and b_i, unpacked into sign, exponent, significand and zero/special flags.
- Stage 2 (edge N+1): register the 48-bit significand product, the exponent sum and the flags.
- Stage 3 (edge N+2): normalize, round, pack, and register into product_o.
- Latency: an operand pair sampled at edge N appears on product_o after edge N+2.
- Throughput: one operation per cycle; no stall or bubble logic.
- Reset: while reset_i = 0 at a rising edge, all pipeline registers and product_o clear to 32'h00000000.
- Reset mid-operation discards all in-flight results.
- After reset is released, product_o reflects the first post-reset operands after 3 edges. Until then it carries products of cleared stages, i.e. 0.
- Operand changes are only sampled on edges; combinational glitches between edges must not reach product_o.

## Configuration
- FP_MUL_SPECIALS_EN defined:
  - Either input NaN → 32'h7FC00000.
  - Inf × zero → 32'h7FC00000.
  - Inf × nonzero → {sign, 8'hFF, 23'b0}.
  - Exponent overflow → signed infinity.
- FP_MUL_SPECIALS_EN undefined:
  - Exponent-255 inputs are treated as ordinary normal numbers.
  - Overflow saturates to signed max finite {sign, 8'hFE, 23'h7FFFFF}.
  - No NaN is ever produced.

## Structure
- Shared package fp32_pkg holds:
  - typedef struct packed fp32_t {sign, exp[7:0], frac[22:0]}.
  - Constants FP32_BIAS = 127, FP32_QNAN = 32'h7FC00000, FP32_POS_INF = 32'h7F800000, FP32_MAX_FINITE = 32'h7F7FFFFF.
- One sub-module, fp_mul_norm_round: combinational stage-3 logic.
  - Inputs: 48-bit product, exponent, sign, flags.
  - Output: packed 32-bit result.
- The top holds the three pipeline register banks.

## Test plan
- Reset low one edge, release; 32'h40200000 × 32'h40800000 (2.5×4) → product_o = 32'h41200000 after 3 edges.
- 32'hC0400000 × 32'h40E00000 (−3×7) → 32'hC1A80000; 32'h3FC00000 × 32'h3FC00000 (1.5×1.5) → 32'h40100000.
- 32'h00000000 × 32'h3F800000 → 32'h00000000; 32'h80000000 × 32'h3F800000 → 32'h80000000; 32'h00800000 × 32'h3F000000 (underflow) → 32'h00000000.
- Rounding: 32'h3F800001 × 32'h3F800001 → 32'h3F800002; back-to-back distinct operand pairs every cycle → each result appears exactly 3 edges after its operands, in order.
- Overflow: 32'h7F000000 × 32'h40000000 → 32'h7F800000 with FP_MUL_SPECIALS_EN, 32'h7F7FFFFF without; with the macro, 32'h7F800000 × 0 → 32'h7FC00000.
- Assert reset_i = 0 with 2 operations in flight → product_o = 0 at the next edge and stays 0 until 3 edges after release.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared binary32 types, constants and operand classification for the FP multiplier.
// Honours FP_MUL_SPECIALS_EN: when defined, exponent-255 operands are classified as Inf/NaN.
package fp32_pkg;

  localparam int          FP32_BIAS       = 127;
  localparam logic [31:0] FP32_QNAN       = 32'h7FC00000;
  localparam logic [31:0] FP32_POS_INF    = 32'h7F800000;
  localparam logic [31:0] FP32_MAX_FINITE = 32'h7F7FFFFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } fp_flags_t;

  // Denormals count as zero; without specials, exponent 255 is just a large normal.
  function automatic fp_flags_t classify(input fp32_t x);
    fp_flags_t f;
    f.zero = (x.exp == 8'h00);
`ifdef FP_MUL_SPECIALS_EN
    f.inf  = (x.exp == 8'hFF) && (x.frac == 23'd0);
    f.nan  = (x.exp == 8'hFF) && (x.frac != 23'd0);
`else
    f.inf  = 1'b0;
    f.nan  = 1'b0;
`endif
    return f;
  endfunction

endpackage

// File: rtl/fp_multiply_if.sv
// Operand/result bundle of the FP multiplier; no handshake, one pair per cycle.
interface fp_multiply_if;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] product_o;

  modport master (output a_i, output b_i, input product_o);
  modport slave  (input a_i, input b_i, output product_o);
endinterface

// File: rtl/fp_mul_norm_round.sv
// Combinational stage 3: normalize, round-to-nearest-even, handle zero/under/overflow, pack.
// FP_MUL_SPECIALS_EN selects overflow to infinity (defined) or to max finite (undefined).
module fp_mul_norm_round
  import fp32_pkg::*;
(
  input  logic [47:0]       prod,
  input  logic signed [9:0] exp_in,
  input  logic              sign,
  input  fp_flags_t         flags_a,
  input  fp_flags_t         flags_b,
  output logic [31:0]       result
);

  logic [22:0]       mant;
  logic [22:0]       mant_r;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic              carry;
  logic signed [9:0] exp_n;

  always_comb begin
    mant     = '0;
    mant_r   = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    round_up = 1'b0;
    carry    = 1'b0;
    exp_n    = exp_in;
    result   = '0;

    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_n  = exp_in + 10'sd1;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end

    round_up        = guard & (sticky | mant[0]);
    {carry, mant_r} = {1'b0, mant} + {23'd0, round_up};
    // A carry-out leaves mant_r all zero, which is exactly 1.0 at the next exponent.
    if (carry) exp_n = exp_n + 10'sd1;

    if (flags_a.nan || flags_b.nan) begin
      result = FP32_QNAN;
    end else if (flags_a.inf || flags_b.inf) begin
      result = (flags_a.zero || flags_b.zero) ? FP32_QNAN : {sign, FP32_POS_INF[30:0]};
    end else if (flags_a.zero || flags_b.zero) begin
      result = {sign, 31'd0};
    end else if (exp_n <= 10'sd0) begin
      result = {sign, 31'd0};
    end else if (exp_n >= 10'sd255) begin
`ifdef FP_MUL_SPECIALS_EN
      result = {sign, FP32_POS_INF[30:0]};
`else
      result = {sign, FP32_MAX_FINITE[30:0]};
`endif
    end else begin
      result = {sign, exp_n[7:0], mant_r};
    end
  end

endmodule

// File: rtl/fp_multiply_top.sv
// Three-stage binary32 multiplier: unpack, significand multiply, normalize/round/pack.
module fp_multiply_top
  import fp32_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  fp_multiply_if.slave  bus
);

  fp32_t a_in;
  fp32_t b_in;
  assign a_in = bus.a_i;
  assign b_in = bus.b_i;

  logic              s1_sign;
  logic [7:0]        s1_ea;
  logic [7:0]        s1_eb;
  logic [23:0]       s1_ma;
  logic [23:0]       s1_mb;
  fp_flags_t         s1_flags_a;
  fp_flags_t         s1_flags_b;

  logic              s2_sign;
  logic [47:0]       s2_prod;
  logic signed [9:0] s2_exp;
  fp_flags_t         s2_flags_a;
  fp_flags_t         s2_flags_b;

  logic [31:0]       s3_result;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      s1_sign    <= 1'b0;
      s1_ea      <= '0;
      s1_eb      <= '0;
      s1_ma      <= '0;
      s1_mb      <= '0;
      s1_flags_a <= '0;
      s1_flags_b <= '0;
    end else begin
      s1_sign    <= a_in.sign ^ b_in.sign;
      s1_ea      <= a_in.exp;
      s1_eb      <= b_in.exp;
      s1_ma      <= {1'b1, a_in.frac};
      s1_mb      <= {1'b1, b_in.frac};
      s1_flags_a <= classify(a_in);
      s1_flags_b <= classify(b_in);
    end
  end

  // Cleared stage 1 yields exponent -127, so a reset pipeline drains as zeros.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      s2_sign    <= 1'b0;
      s2_prod    <= '0;
      s2_exp     <= '0;
      s2_flags_a <= '0;
      s2_flags_b <= '0;
    end else begin
      s2_sign    <= s1_sign;
      s2_prod    <= s1_ma * s1_mb;
      s2_exp     <= $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - 10'(FP32_BIAS);
      s2_flags_a <= s1_flags_a;
      s2_flags_b <= s1_flags_b;
    end
  end

  fp_mul_norm_round u_norm_round (
    .prod    (s2_prod),
    .exp_in  (s2_exp),
    .sign    (s2_sign),
    .flags_a (s2_flags_a),
    .flags_b (s2_flags_b),
    .result  (s3_result)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      bus.product_o <= '0;
    end else begin
      bus.product_o <= s3_result;
    end
  end

endmodule

// File: tb/tb_fp_multiply_top.sv
// Directed-vector bench for fp_multiply_top; expectations follow FP_MUL_SPECIALS_EN.
module tb_fp_multiply_top;

  logic clk_i = 1'b0;
  logic reset_i;

  fp_multiply_if bus ();

  fp_multiply_top dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b);
    bus.a_i = a;
    bus.b_i = b;
  endtask

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p, input string tag);
    vec_t v;
    v.a = a; v.b = b; v.p = p; v.tag = tag;
    vecs.push_back(v);
  endtask

  initial begin
    add_vec(32'h40200000, 32'h40800000, 32'h41200000, "2.5x4");
    add_vec(32'hC0400000, 32'h40E00000, 32'hC1A80000, "-3x7");
    add_vec(32'h3FC00000, 32'h3FC00000, 32'h40100000, "1.5x1.5");
    add_vec(32'h00000000, 32'h3F800000, 32'h00000000, "+0x1");
    add_vec(32'h80000000, 32'h3F800000, 32'h80000000, "-0x1");
    add_vec(32'h00800000, 32'h3F000000, 32'h00000000, "underflow");
    add_vec(32'h3F800001, 32'h3F800001, 32'h3F800002, "lsb_product");
    add_vec(32'h3FC00001, 32'h3FC00001, 32'h40100002, "round_up");
    add_vec(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, "truncate");
    add_vec(32'h3F800000, 32'hBF800000, 32'hBF800000, "1x-1");
    add_vec(32'h00000001, 32'h40000000, 32'h00000000, "denorm_ftz");
    add_vec(32'h00400000, 32'hC0000000, 32'h80000000, "neg_denorm_ftz");
`ifdef FP_MUL_SPECIALS_EN
    add_vec(32'h7F000000, 32'h40000000, 32'h7F800000, "overflow_inf");
    add_vec(32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_x_zero");
    add_vec(32'h7FC00000, 32'h3F800000, 32'h7FC00000, "nan_in");
    add_vec(32'hFF800000, 32'h40000000, 32'hFF800000, "neg_inf");
`else
    add_vec(32'h7F000000, 32'h40000000, 32'h7F7FFFFF, "overflow_sat");
    add_vec(32'h7F800000, 32'h3F000000, 32'h7F000000, "exp255_normal");
`endif

    // One reset edge with live operands on the bus.
    reset_i = 1'b0;
    apply_stimulus(32'h40200000, 32'h40800000);
    @(negedge clk_i);
    check_output("reset_state", bus.product_o, 32'h0);
    reset_i = 1'b1;

    // Back-to-back: vector j is sampled at edge j and checked after edge j+2.
    for (int j = 0; j < vecs.size() + 3; j++) begin
      if (j >= 3) check_output(vecs[j-3].tag, bus.product_o, vecs[j-3].p);
      if (j < vecs.size()) apply_stimulus(vecs[j].a, vecs[j].b);
      else apply_stimulus(32'h0, 32'h0);
      @(negedge clk_i);
    end

    // Reset with two operations in flight.
    apply_stimulus(32'h40200000, 32'h40800000);
    @(negedge clk_i);
    apply_stimulus(32'hC0400000, 32'h40E00000);
    @(negedge clk_i);
    reset_i = 1'b0;
    apply_stimulus(32'h3FC00000, 32'h3FC00000);
    @(negedge clk_i);
    check_output("midflight_reset", bus.product_o, 32'h0);
    reset_i = 1'b1;
    @(negedge clk_i);
    check_output("post_reset_e1", bus.product_o, 32'h0);
    @(negedge clk_i);
    check_output("post_reset_e2", bus.product_o, 32'h0);
    @(negedge clk_i);
    check_output("post_reset_e3", bus.product_o, 32'h40100000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
